line_window_bram: RTL
=====================

# line_window_bram

Streaming K-row line buffer for the conv front end. It accepts one pixel beat per cycle, holding P_CH channels of DWIDTH bits, in row-major order. It stores the previous rows in K single-port BRAM banks and emits a vertical K-pixel column per accepted pixel once K rows are available. It sits between the feature-map reader and the KxK window/MAC array. It adds a runtime image size, valid/ready backpressure, bank rotation and frame tracking, none of which the single-bank line RAM has.

## Interface
- DWIDTH, 8, bits per channel
- P_CH, 32, channels per pixel beat
- K, 3, window height (rows per output column), 2..7
- MAX_WIDTH, 224, max pixels per row = depth of each bank
- AWIDTH, 8, column address width, 2^AWIDTH >= MAX_WIDTH
- HWIDTH, 8, row counter width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- img_width  in  AWIDTH  pixels per row; sampled on the first beat of each frame
- img_height  in  HWIDTH  rows per frame; sampled on the first beat of each frame
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  DWIDTH*P_CH  input pixel
- m_valid  out  1  output column valid
- m_ready  in  1  downstream accepts
- m_data  out  K*DWIDTH*P_CH  column; slice 0 = oldest row (r-K+1), slice K-1 = current row r
- m_col  out  AWIDTH  column index of m_data
- m_last  out  1  m_data is the last column of a row
- m_frame_end  out  1  m_data is the last column of the frame
- cfg_err  out  1  latched config error

## Operation
- Banks 0..K-1 each hold MAX_WIDTH x (DWIDTH*P_CH). Each bank has one port with ce/we, and read XOR write per cycle.
- Counters: col (0..W-1), row (0..H-1), wr_bank (0..K-1, wraps K-1 to 0 at each row end).
- Pipeline advance: en = s_ready = (m_valid==0 | m_ready) & !cfg_err.
- Stage 1, on an accepted beat (en & s_valid):
  - write s_data to bank wr_bank at col;
  - read the other K-1 banks at col;
  - capture s_data, col, row and the bank order into stage-1 registers.
- Stage 2: BRAM Q plus the delayed s_data are reordered by bank age into m_data. Outputs are registered.
- m_valid is set only for beats with row >= K-1. Rows 0..K-2 are absorbed silently, with no padding.
- When en = 0, every bank holds ce low, so Q is held. No beat is lost or duplicated under backpressure.
- End of row: col reaches W-1, so col goes to 0, row increments and wr_bank rotates.
- End of frame: col = W-1 and row = H-1. Counters and wr_bank return to 0, and the next beat resamples the config.
- Config error: img_width = 0, img_width > MAX_WIDTH, or img_height < K at frame start.
  - cfg_err is set and s_ready held at 0.
  - Cleared only by rst_n.
- Bank contents are not cleared on reset or at frame start. Stale data is never output, because rows < K-1 are masked.

## Timing
- Reset values: s_ready 0 while rst_n is low, then 1. m_valid 0, m_data 0, m_col 0, m_last 0, m_frame_end 0, cfg_err 0. All counters 0, wr_bank 0.
- Reset mid-frame: the pipeline is flushed and in-flight beats are discarded. The next beat is treated as row 0, col 0 of a new frame.
- Latency: a beat accepted at edge t appears on m_* after edge t+2, given no stall. A stall adds its cycle count one-for-one.
- Throughput: 1 column per cycle with m_ready held high.
- m_data, m_col, m_last and m_frame_end stay stable while m_valid & !m_ready.
- A single-port conflict cannot occur, because the bank being written is never read in the same cycle.
- W = 1: every beat is row end, and the bank rotates every beat.

## Test plan
- K=3, W=4, H=4, ramp data (value = row*16+col, all channels), m_ready=1. Required:
  - no m_valid for the first 8 beats;
  - then 8 columns, the first being {0x00,0x10,0x20} at m_col 0;
  - m_last on cols 3; m_frame_end only on the final column {0x13,0x23,0x33}.
- Same stream with m_ready toggled pseudo-randomly at 50% and s_valid gaps. Required: an identical output sequence, no drops or duplicates, and m_data stable during stalls.
- Two back-to-back frames, W=4/H=3 then W=224/H=5. Required: the second frame's first output is at row 2 and contains no frame-1 data; 224*3 columns are emitted.
- img_width=0 or img_height=2 with K=3. Required: cfg_err=1 and s_ready=0 from the cycle after the first beat; cfg_err clears only on rst_n.
- Assert rst_n low mid-row 2 of W=4. Required: all outputs go to their reset values asynchronously; after release, the next frame's output matches the first scenario exactly.
- W=1, H=5, K=3. Required: outputs {r0,r1,r2}, {r1,r2,r3}, {r2,r3,r4}, each with m_last=1, and m_frame_end on the third.

Source files
------------

// File: rtl/line_window_bram.sv
// K-row line buffer: stores the previous K-1 rows in rotating single-port banks and
// emits one vertical K-pixel column per accepted pixel once K rows of a frame exist.
module line_window_bram #(
  parameter int DWIDTH    = 8,
  parameter int P_CH      = 32,
  parameter int K         = 3,
  parameter int MAX_WIDTH = 224,
  parameter int AWIDTH    = 8,
  parameter int HWIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AWIDTH-1:0]          img_width,
  input  logic [HWIDTH-1:0]          img_height,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DWIDTH*P_CH-1:0]     s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [K*DWIDTH*P_CH-1:0]   m_data,
  output logic [AWIDTH-1:0]          m_col,
  output logic                       m_last,
  output logic                       m_frame_end,
  output logic                       cfg_err
);
  localparam int DATA = DWIDTH * P_CH;
  localparam int BW   = (K > 1) ? $clog2(K) : 1;
  localparam logic [AWIDTH:0]   MAX_W     = (AWIDTH+1)'(MAX_WIDTH);
  localparam logic [HWIDTH-1:0] MIN_H     = HWIDTH'(K);
  localparam logic [HWIDTH-1:0] OUT_ROW   = HWIDTH'(K - 1);
  localparam logic [BW-1:0]     LAST_BANK = BW'(K - 1);

  logic              en, accept, store, first_beat, bad_cfg, row_end, frame_end;
  logic [AWIDTH-1:0] col, cur_w, eff_w;
  logic [HWIDTH-1:0] row, cur_h, eff_h;
  logic [BW-1:0]     wr_bank;

  // Handshake: a beat moves on s_* when s_valid & s_ready at a rising edge, and a column
  // moves on m_* when m_valid & m_ready; the whole pipeline advances together on en.
  assign en         = (!m_valid || m_ready) && !cfg_err;
  assign s_ready    = en && rst_n;
  assign accept     = en && s_valid;
  assign first_beat = (col == '0) && (row == '0);
  assign bad_cfg    = first_beat && ((img_width == '0) || ({1'b0, img_width} > MAX_W) ||
                                     (img_height < MIN_H));
  assign store      = accept && !bad_cfg;
  assign eff_w      = first_beat ? img_width  : cur_w;
  assign eff_h      = first_beat ? img_height : cur_h;
  assign row_end    = (col == eff_w - 1'b1);
  assign frame_end  = row_end && (row == eff_h - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      wr_bank <= '0;
      cur_w   <= '0;
      cur_h   <= '0;
      cfg_err <= 1'b0;
    end else if (accept) begin
      if (bad_cfg) begin
        cfg_err <= 1'b1;
      end else begin
        if (first_beat) begin
          cur_w <= img_width;
          cur_h <= img_height;
        end
        if (frame_end) begin
          col     <= '0;
          row     <= '0;
          wr_bank <= '0;
        end else if (row_end) begin
          col     <= '0;
          row     <= row + 1'b1;
          wr_bank <= (wr_bank == LAST_BANK) ? '0 : wr_bank + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Stage registers: s1 alongside the bank access, s2 alongside the registered bank output.
  logic              s1_valid, s1_last, s1_fend, s2_valid, s2_last, s2_fend;
  logic [DATA-1:0]   s1_data, s2_data;
  logic [AWIDTH-1:0] s1_col, s2_col;
  logic [BW-1:0]     s1_bank, s2_bank;
  logic [DATA-1:0]   q_all [K];
  logic [K*DATA-1:0] col_data;

  for (genvar b = 0; b < K; b++) begin : g_bank
    logic [DATA-1:0] mem [MAX_WIDTH];
    logic [DATA-1:0] q_raw, q_pipe;
    logic            we;

    assign we = store && (wr_bank == BW'(b));

    // ce follows store, so a stall freezes q_raw until the next stage can take it.
    always_ff @(posedge clk) begin
      if (store) begin
        if (we) mem[col] <= s_data;
        else    q_raw    <= mem[col];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q_pipe <= '0;
      else if (en) q_pipe <= q_raw;
    end

    assign q_all[b] = q_pipe;
  end

  // Slice j holds row r-K+1+j, which lives in bank (newest + 1 + j) mod K.
  for (genvar j = 0; j < K - 1; j++) begin : g_order
    logic [BW:0]   sum;
    logic [BW-1:0] sel;
    assign sum = {1'b0, s2_bank} + (BW+1)'(j + 1);
    assign sel = (sum >= (BW+1)'(K)) ? BW'(sum - (BW+1)'(K)) : BW'(sum);
    assign col_data[j*DATA +: DATA] = q_all[sel];
  end
  assign col_data[(K-1)*DATA +: DATA] = s2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_fend     <= 1'b0;
      s1_data     <= '0;
      s1_col      <= '0;
      s1_bank     <= '0;
      s2_valid    <= 1'b0;
      s2_last     <= 1'b0;
      s2_fend     <= 1'b0;
      s2_data     <= '0;
      s2_col      <= '0;
      s2_bank     <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_col       <= '0;
      m_last      <= 1'b0;
      m_frame_end <= 1'b0;
    end else if (en) begin
      s1_valid    <= store && (row >= OUT_ROW);
      s1_last     <= row_end;
      s1_fend     <= frame_end;
      s1_data     <= s_data;
      s1_col      <= col;
      s1_bank     <= wr_bank;
      s2_valid    <= s1_valid;
      s2_last     <= s1_last;
      s2_fend     <= s1_fend;
      s2_data     <= s1_data;
      s2_col      <= s1_col;
      s2_bank     <= s1_bank;
      m_valid     <= s2_valid;
      m_data      <= col_data;
      m_col       <= s2_col;
      m_last      <= s2_last;
      m_frame_end <= s2_fend;
    end
  end
endmodule
